// File: rtl/board_dump_tx.sv
// Serial board-dump transmitter: snapshots the packed 64-square board on START
// and streams it as 80 ASCII bytes (8 ranks of 8 squares plus CR LF) over 8N1 UART.
module board_dump_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [255:0] BOARD,
    input  logic         START,
    output logic         TX,
    output logic         BUSY,
    output logic         DONE
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START_BIT,
        S_DATA,
        S_STOP_BIT
    } state_t;

    state_t             r_state;
    logic [255:0]       r_snap;
    logic [CNT_W-1:0]   r_baud;
    logic [2:0]         r_bitCnt;
    logic [6:0]         r_byteIdx;
    logic [2:0]         r_row;
    logic [3:0]         r_pos;
    logic [7:0]         r_data;
    logic               r_tx;
    logic               r_busy;
    logic               r_done;

    state_t             w_state;
    logic [255:0]       w_snap;
    logic [CNT_W-1:0]   w_baud;
    logic [2:0]         w_bitCnt;
    logic [6:0]         w_byteIdx;
    logic [2:0]         w_row;
    logic [3:0]         w_pos;
    logic [7:0]         w_data;
    logic               w_tx;
    logic               w_busy;
    logic               w_done;

    logic               w_baudEnd;
    logic               w_lastByte;
    logic               w_lastPos;
    logic [3:0]         w_nextPos;
    logic [2:0]         w_nextRow;
    logic [5:0]         w_sqSel;
    logic [3:0]         w_nextSq;
    logic [7:0]         w_nextChar;
    logic [2:0]         w_bitNext;

    // Black letters are the lowercase of white; empty and code 7 have no case.
    function automatic logic [7:0] f_charOf(input logic [3:0] sq);
        logic [7:0] c;
        case (sq[2:0])
            3'd0:    c = 8'h2E;
            3'd1:    c = 8'h50;
            3'd2:    c = 8'h4E;
            3'd3:    c = 8'h42;
            3'd4:    c = 8'h52;
            3'd5:    c = 8'h51;
            3'd6:    c = 8'h4B;
            default: c = 8'h3F;
        endcase
        if (sq[3] && (sq[2:0] != 3'd0) && (sq[2:0] != 3'd7)) begin
            c = c + 8'h20;
        end
        return c;
    endfunction

    assign w_baudEnd  = (r_baud == CNT_W'(CLKS_PER_BIT - 1));
    assign w_lastByte = (r_byteIdx == 7'd79);
    assign w_lastPos  = (r_pos == 4'd9);
    assign w_nextPos  = w_lastPos ? 4'd0 : (r_pos + 4'd1);
    assign w_nextRow  = w_lastPos ? (r_row + 3'd1) : r_row;
    assign w_sqSel    = {w_nextRow, w_nextPos[2:0]};
    assign w_nextSq   = r_snap[{w_sqSel, 2'b00} +: 4];
    assign w_nextChar = (w_nextPos == 4'd8) ? 8'h0D :
                        (w_nextPos == 4'd9) ? 8'h0A : f_charOf(w_nextSq);
    assign w_bitNext  = r_bitCnt + 3'd1;

    always_comb begin
        w_state   = r_state;
        w_snap    = r_snap;
        w_baud    = r_baud;
        w_bitCnt  = r_bitCnt;
        w_byteIdx = r_byteIdx;
        w_row     = r_row;
        w_pos     = r_pos;
        w_data    = r_data;
        w_tx      = r_tx;
        w_busy    = r_busy;
        w_done    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud   = '0;
                w_bitCnt = 3'd0;
                if (START) begin
                    w_state   = S_START_BIT;
                    w_snap    = BOARD;
                    w_byteIdx = 7'd0;
                    w_row     = 3'd0;
                    w_pos     = 4'd0;
                    w_data    = f_charOf(BOARD[3:0]);
                    w_tx      = 1'b0;
                    w_busy    = 1'b1;
                end
            end
            S_START_BIT: begin
                if (w_baudEnd) begin
                    w_baud   = '0;
                    w_state  = S_DATA;
                    w_bitCnt = 3'd0;
                    w_tx     = r_data[0];
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baudEnd) begin
                    w_baud = '0;
                    if (r_bitCnt == 3'd7) begin
                        w_state = S_STOP_BIT;
                        w_tx    = 1'b1;
                    end else begin
                        w_bitCnt = w_bitNext;
                        w_tx     = r_data[w_bitNext];
                    end
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end
            S_STOP_BIT: begin
                if (w_baudEnd) begin
                    w_baud = '0;
                    if (w_lastByte) begin
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_tx    = 1'b1;
                    end else begin
                        // Next byte is loaded here so its start bit follows with no gap.
                        w_state   = S_START_BIT;
                        w_byteIdx = r_byteIdx + 7'd1;
                        w_row     = w_nextRow;
                        w_pos     = w_nextPos;
                        w_data    = w_nextChar;
                        w_tx      = 1'b0;
                    end
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_snap    <= '0;
            r_baud    <= '0;
            r_bitCnt  <= 3'd0;
            r_byteIdx <= 7'd0;
            r_row     <= 3'd0;
            r_pos     <= 4'd0;
            r_data    <= 8'd0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_snap    <= w_snap;
            r_baud    <= w_baud;
            r_bitCnt  <= w_bitCnt;
            r_byteIdx <= w_byteIdx;
            r_row     <= w_row;
            r_pos     <= w_pos;
            r_data    <= w_data;
            r_tx      <= w_tx;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    assign TX   = r_tx;
    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule

// File: tb/tb_board_dump_tx.sv
// Scoreboard bench for board_dump_tx: expected bytes are queued when a dump is
// requested and a UART decoder pops and compares each received byte.
module tb_board_dump_tx;

    localparam int CPB = 4;
    localparam int FRAME = 800 * CPB;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [255:0] BOARD = '0;
    logic         START = 1'b0;
    logic         TX;
    logic         BUSY;
    logic         DONE;

    int assertCount = 0;
    int failCount = 0;
    int cycleCount = 0;
    int e0 = 0;

    logic [7:0] expQ[$];

    int         rxActive = 0;
    int         rxCnt = 0;
    logic [7:0] rxByte = 8'd0;
    logic [7:0] rxExp;

    board_dump_tx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .BOARD (BOARD),
        .START (START),
        .TX    (TX),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycleCount <= cycleCount + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] charOf(input logic [3:0] sq);
        logic [7:0] c;
        case (sq)
            4'h0, 4'h8: c = ".";
            4'h1: c = "P";
            4'h2: c = "N";
            4'h3: c = "B";
            4'h4: c = "R";
            4'h5: c = "Q";
            4'h6: c = "K";
            4'h9: c = "p";
            4'hA: c = "n";
            4'hB: c = "b";
            4'hC: c = "r";
            4'hD: c = "q";
            4'hE: c = "k";
            default: c = "?";
        endcase
        return c;
    endfunction

    function automatic logic [3:0] backPiece(input int col);
        logic [3:0] p;
        case (col)
            0, 7: p = 4'd4;
            1, 6: p = 4'd2;
            2, 5: p = 4'd3;
            3:    p = 4'd5;
            default: p = 4'd6;
        endcase
        return p;
    endfunction

    function automatic logic [255:0] initialBoard();
        logic [255:0] b;
        logic [3:0]   p;
        b = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                p = 4'd0;
                if (r == 0 || r == 7) p = backPiece(c);
                else if (r == 1 || r == 6) p = 4'd1;
                if (r < 2 && p != 4'd0) p = p | 4'h8;
                b[(r*8+c)*4 +: 4] = p;
            end
        end
        return b;
    endfunction

    task automatic pushBoard(input logic [255:0] b);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) expQ.push_back(charOf(b[(r*8+c)*4 +: 4]));
            expQ.push_back(8'h0D);
            expQ.push_back(8'h0A);
        end
    endtask

    task automatic pushInitialText();
        string rows[8];
        rows = '{"rnbqkbnr", "pppppppp", "........", "........",
                 "........", "........", "PPPPPPPP", "RNBQKBNR"};
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) expQ.push_back(rows[r][c]);
            expQ.push_back(8'h0D);
            expQ.push_back(8'h0A);
        end
    endtask

    task automatic applyStimulus(input logic [255:0] b);
        @(negedge CLK);
        BOARD = b;
        START = 1'b1;
        @(posedge CLK);
        #1;
        e0 = cycleCount;
        START = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int expLatency);
        int found;
        found = 0;
        for (int n = 0; n < FRAME + 200; n++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                found = 1;
                break;
            end
        end
        checkOutput({tag, "_doneSeen"}, found, 1);
        if (found == 1) begin
            checkOutput({tag, "_latency"}, cycleCount - e0, expLatency);
            checkOutput({tag, "_busyLow"}, BUSY, 1'b0);
            checkOutput({tag, "_txIdle"}, TX, 1'b1);
            @(negedge CLK);
            checkOutput({tag, "_donePulse"}, DONE, 1'b0);
        end
        checkOutput({tag, "_queueDrained"}, expQ.size(), 0);
    endtask

    task automatic waitUntil(input int offset);
        for (int n = 0; n < FRAME + 200; n++) begin
            if (cycleCount - e0 >= offset) break;
            @(negedge CLK);
        end
    endtask

    task automatic pulseReset();
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        checkOutput("reset_tx", TX, 1'b1);
        checkOutput("reset_busy", BUSY, 1'b0);
        checkOutput("reset_done", DONE, 1'b0);
        expQ.delete();
        repeat (3) begin
            @(negedge CLK);
            checkOutput("reset_noDone", DONE, 1'b0);
        end
        RESET = 1'b0;
    endtask

    // UART decoder: samples mid-bit on falling clock edges, then scores each byte.
    always @(negedge CLK) begin
        if (RESET) begin
            rxActive = 0;
        end else if (rxActive == 0) begin
            if (TX === 1'b0) begin
                rxActive = 1;
                rxCnt = 0;
            end
        end else begin
            rxCnt++;
            if (rxCnt == CPB/2) begin
                checkOutput("rx_startBit", TX, 1'b0);
            end else if (rxCnt > CPB/2 && (rxCnt - CPB/2) % CPB == 0) begin
                if ((rxCnt - CPB/2) / CPB <= 8) begin
                    rxByte = {TX, rxByte[7:1]};
                end else begin
                    checkOutput("rx_stopBit", TX, 1'b1);
                    checkOutput("rx_queueHasEntry", (expQ.size() > 0), 1'b1);
                    if (expQ.size() > 0) begin
                        rxExp = expQ.pop_front();
                        checkOutput("rx_byte", rxByte, rxExp);
                    end
                    rxActive = 0;
                end
            end
        end
    end

    initial begin : main
        logic [255:0] b;
        logic [255:0] bMod;
        int           doneCnt;
        int           busyLow;
        int           done1;
        int           done2;
        int           levels[10];

        $display("[TB] reset state");
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rst_tx", TX, 1'b1);
        checkOutput("rst_busy", BUSY, 1'b0);
        checkOutput("rst_done", DONE, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        $display("[TB] initial board dump with bit-level check of byte 0");
        b = initialBoard();
        pushInitialText();
        applyStimulus(b);
        checkOutput("start_busy", BUSY, 1'b1);
        checkOutput("start_tx", TX, 1'b0);
        levels = '{0, 0, 1, 0, 0, 1, 1, 1, 0, 1};
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge CLK);
            checkOutput($sformatf("byte0_bit%0d", k / CPB), TX, levels[k / CPB]);
        end
        waitDone("initial", FRAME);

        $display("[TB] snapshot and busy-ignore");
        repeat (3) @(negedge CLK);
        pushInitialText();
        applyStimulus(b);
        waitUntil(100);
        bMod = b;
        bMod[3:0] = 4'h6;
        BOARD = bMod;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        waitDone("snapshot", FRAME);
        doneCnt = 0;
        repeat (10) begin
            @(negedge CLK);
            if (DONE === 1'b1) doneCnt++;
        end
        checkOutput("snapshot_noExtraDone", doneCnt, 0);
        checkOutput("snapshot_noRestart", BUSY, 1'b0);
        pushBoard(bMod);
        applyStimulus(bMod);
        waitDone("modified", FRAME);

        $display("[TB] edge piece codes");
        bMod = b;
        bMod[3:0]  = 4'h8;
        bMod[7:4]  = 4'h7;
        bMod[11:8] = 4'hF;
        pushBoard(bMod);
        applyStimulus(bMod);
        waitDone("edgeCodes", FRAME);

        $display("[TB] reset mid-frame");
        pushBoard(b);
        applyStimulus(b);
        waitUntil(1000);
        pulseReset();
        repeat (2) @(negedge CLK);
        checkOutput("postReset_idle", BUSY, 1'b0);
        pushBoard(b);
        applyStimulus(b);
        waitDone("afterReset", FRAME);

        $display("[TB] held START");
        repeat (3) @(negedge CLK);
        pushBoard(b);
        pushBoard(b);
        pushBoard(b);
        @(negedge CLK);
        BOARD = b;
        START = 1'b1;
        @(posedge CLK);
        #1;
        e0 = cycleCount;
        doneCnt = 0;
        busyLow = 0;
        done1 = -1;
        done2 = -1;
        while (cycleCount - e0 < 7000) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                doneCnt++;
                if (doneCnt == 1) done1 = cycleCount - e0;
                if (doneCnt == 2) done2 = cycleCount - e0;
            end
            if (doneCnt == 1 && BUSY === 1'b0) busyLow++;
        end
        START = 1'b0;
        checkOutput("held_doneCount", doneCnt, 2);
        checkOutput("held_done1", done1, FRAME);
        checkOutput("held_done2", done2, 2 * FRAME + 1);
        checkOutput("held_busyGap", busyLow, 1);
        pulseReset();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
